// File: rtl/stamp_stream_source.sv
// stamp_stream_source
//   AXI4-Stream master that plays a stored stamp image out row by row.
//   Pixels are loaded through a simple write port into an internal pixel RAM
//   with synchronous reads. A rising edge on GO streams one frame; DONE marks
//   completion and ERROR flags illegal frame dimensions.
//
//   Build option: define STAMP_SRC_REPEAT_EN to keep streaming frames
//   back-to-back while GO stays high. DONE then pulses once per frame and
//   only becomes sticky when GO=0 ends the stream.
//
// Ports
//   M_AXIS_ACLK / M_AXIS_ARESETN  clock, asynchronous active-low reset
//   GO, X_IN, Y_IN                frame start (rising edge), pixels/row, rows
//   wr_en, wr_addr, wr_data       pixel RAM write port (dropped while BUSY)
//   BUSY, DONE, ERROR             status
//   M_AXIS_*                      stream master (TLAST = end of row,
//                                 TUSER = first pixel of frame)
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a GO rising edge
// CHECK   | validate latched dimensions (zero or over RAM capacity)
// PRIME   | read of pixel 0 in flight
// STREAM  | TVALID high, TDATA = RAM[idx]
// FINISH  | TVALID low, DONE set on exit

module stamp_stream_source #(
   parameter int C_M_AXIS_TDATA_WIDTH = 32,
   parameter int C_ADDR_WIDTH         = 12,
   parameter int C_DIM_WIDTH          = 10
) (
   input  logic                              M_AXIS_ACLK,
   input  logic                              M_AXIS_ARESETN,
   input  logic                              GO,
   input  logic [C_DIM_WIDTH-1:0]            X_IN,
   input  logic [C_DIM_WIDTH-1:0]            Y_IN,
   input  logic                              wr_en,
   input  logic [C_ADDR_WIDTH-1:0]           wr_addr,
   input  logic [C_M_AXIS_TDATA_WIDTH-1:0]   wr_data,
   output logic                              BUSY,
   output logic                              DONE,
   output logic                              ERROR,
   output logic                              M_AXIS_TVALID,
   output logic [C_M_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
   output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TSTRB,
   output logic                              M_AXIS_TLAST,
   output logic                              M_AXIS_TUSER,
   input  logic                              M_AXIS_TREADY
);

   localparam int AW = C_ADDR_WIDTH;
   localparam int DW = C_DIM_WIDTH;
   localparam int TW = C_M_AXIS_TDATA_WIDTH;
   localparam logic [2*DW-1:0] CAPACITY = (2*DW)'(2**AW);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_PRIME,
      S_STREAM,
      S_FINISH
   } state_t;

   state_t          state_r, state_nx;
   logic            go_q;
   logic            go_rise;
   logic [DW-1:0]   x_r, y_r;
   logic [DW-1:0]   col_r, row_r;
   logic [AW:0]     idx_r;
   logic [AW:0]     idx_inc;
   logic [2*DW-1:0] area;
   logic            dims_bad;
   logic            xfer;
   logic            last_col;
   logic            last_row;
   logic            frame_end;
   logic            wrap;
   logic            busy;
   logic            done_r;
   logic            error_r;
   logic            rd_en;
   logic [AW-1:0]   rd_addr;
   logic [TW-1:0]   rd_data_r;
   logic [TW-1:0]   mem [0:2**AW-1];

   assign go_rise   = GO & ~go_q;
   assign xfer      = (state_r == S_STREAM) & M_AXIS_TREADY;
   assign last_col  = (col_r == x_r - 1'b1);
   assign last_row  = (row_r == y_r - 1'b1);
   assign frame_end = xfer & last_col & last_row;
   assign idx_inc   = idx_r + (AW+1)'(xfer);
   assign busy      = (state_r == S_CHECK) | (state_r == S_PRIME) | (state_r == S_STREAM);

   // full-width product so an oversized frame cannot alias into range
   assign area     = {{DW{1'b0}}, x_r} * {{DW{1'b0}}, y_r};
   assign dims_bad = (x_r == '0) | (y_r == '0) | (area > CAPACITY);

`ifdef STAMP_SRC_REPEAT_EN
   assign wrap = frame_end & GO;
`else
   assign wrap = 1'b0;
`endif

   always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
      if (!M_AXIS_ARESETN) state_r <= S_IDLE;
      else                 state_r <= state_nx;
   end

   always_comb begin
      state_nx = state_r;
      case (state_r)
         S_IDLE:   if (go_rise) state_nx = S_CHECK;
         S_CHECK:  state_nx = dims_bad ? S_IDLE : S_PRIME;
         S_PRIME:  state_nx = S_STREAM;
         S_STREAM: if (frame_end && !wrap) state_nx = S_FINISH;
         S_FINISH: state_nx = S_IDLE;
         default:  state_nx = S_IDLE;
      endcase
   end

   // Read address runs one beat ahead on a transfer and re-reads the current
   // pixel on a stall, so the registered RAM output holds TDATA steady.
   always_comb begin
      rd_en   = 1'b0;
      rd_addr = '0;
      case (state_r)
         S_PRIME:  rd_en = 1'b1;
         S_STREAM: begin
            rd_en   = 1'b1;
            rd_addr = wrap ? '0 : idx_inc[AW-1:0];
         end
         default: ;
      endcase
   end

   always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
      if (!M_AXIS_ARESETN) begin
         go_q    <= 1'b0;
         x_r     <= '0;
         y_r     <= '0;
         col_r   <= '0;
         row_r   <= '0;
         idx_r   <= '0;
         done_r  <= 1'b0;
         error_r <= 1'b0;
      end else begin
         go_q <= GO;
         case (state_r)
            S_IDLE: begin
               if (go_rise) begin
                  x_r     <= X_IN;
                  y_r     <= Y_IN;
                  col_r   <= '0;
                  row_r   <= '0;
                  idx_r   <= '0;
                  done_r  <= 1'b0;
                  error_r <= 1'b0;
               end
            end
            S_CHECK: begin
               if (dims_bad) error_r <= 1'b1;
            end
            S_STREAM: begin
               // one-cycle pulse per wrapped frame in repeat mode, else stays 0
               done_r <= wrap;
               if (frame_end) begin
                  col_r <= '0;
                  row_r <= '0;
                  idx_r <= '0;
               end else if (xfer) begin
                  idx_r <= idx_inc;
                  if (last_col) begin
                     col_r <= '0;
                     row_r <= row_r + 1'b1;
                  end else begin
                     col_r <= col_r + 1'b1;
                  end
               end
            end
            S_FINISH: done_r <= 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge M_AXIS_ACLK) begin
      if (wr_en && !busy) mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
      if (!M_AXIS_ARESETN)  rd_data_r <= '0;
      else if (rd_en)       rd_data_r <= mem[rd_addr];
   end

   assign BUSY          = busy;
   assign DONE          = done_r;
   assign ERROR         = error_r;
   assign M_AXIS_TVALID = (state_r == S_STREAM);
   assign M_AXIS_TDATA  = rd_data_r;
   assign M_AXIS_TSTRB  = '1;
   assign M_AXIS_TLAST  = (state_r == S_STREAM) & last_col;
   assign M_AXIS_TUSER  = (state_r == S_STREAM) & (idx_r == '0);

endmodule

// File: tb/tb_stamp_stream_source.sv
// Directed bench for stamp_stream_source: reset values, full-rate 8x8 frame,
// stalled 5x5 frame, illegal dimensions, mid-frame reset, write-while-busy,
// 1x1 frame, and GO-level behaviour (single frame or repeat build).
module tb_stamp_stream_source;
   localparam int TW = 32;
   localparam int AW = 12;
   localparam int DW = 10;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            go = 1'b0;
   logic [DW-1:0]   x_in = '0;
   logic [DW-1:0]   y_in = '0;
   logic            wr_en = 1'b0;
   logic [AW-1:0]   wr_addr = '0;
   logic [TW-1:0]   wr_data = '0;
   logic            tready = 1'b0;
   logic            busy, done, error, tvalid, tlast, tuser;
   logic [TW-1:0]   tdata;
   logic [TW/8-1:0] tstrb;

   int total = 0;
   int bad = 0;

   stamp_stream_source #(
      .C_M_AXIS_TDATA_WIDTH(TW), .C_ADDR_WIDTH(AW), .C_DIM_WIDTH(DW)
   ) dut (
      .M_AXIS_ACLK(clk), .M_AXIS_ARESETN(rst_n), .GO(go), .X_IN(x_in), .Y_IN(y_in),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .BUSY(busy), .DONE(done), .ERROR(error),
      .M_AXIS_TVALID(tvalid), .M_AXIS_TDATA(tdata), .M_AXIS_TSTRB(tstrb),
      .M_AXIS_TLAST(tlast), .M_AXIS_TUSER(tuser), .M_AXIS_TREADY(tready)
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic load_ramp(input int n);
      @(negedge clk);
      for (int i = 0; i < n; i++) begin
         wr_en = 1'b1; wr_addr = AW'(i); wr_data = TW'(i);
         @(negedge clk);
      end
      wr_en = 1'b0;
   endtask

   task automatic do_write(input int a, input logic [TW-1:0] d);
      @(negedge clk);
      wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   // Leaves the bench at the negedge of the CHECK cycle.
   task automatic pulse_go(input int x, input int y);
      @(negedge clk);
      x_in = DW'(x); y_in = DW'(y); go = 1'b1;
      @(negedge clk);
      go = 1'b0;
   endtask

   // Consumes beats with TREADY=1 until DONE; no checking here.
   task automatic drain(input int budget, output int beats, output bit reached);
      tready = 1'b1; beats = 0; reached = 1'b0;
      for (int c = 0; c < budget; c++) begin
         if (done) begin reached = 1'b1; break; end
         if (tvalid) beats++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      total++; if (tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid got=%0b want=0", tvalid); end
      total++; if (tlast !== 1'b0) begin bad++; $display("FAIL reset_tlast got=%0b want=0", tlast); end
      total++; if (tuser !== 1'b0) begin bad++; $display("FAIL reset_tuser got=%0b want=0", tuser); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b want=0", done); end
      total++; if (error !== 1'b0) begin bad++; $display("FAIL reset_error got=%0b want=0", error); end
      total++; if (tdata !== '0) begin bad++; $display("FAIL reset_tdata got=%0h want=0", tdata); end
      total++; if (tstrb !== 4'hF) begin bad++; $display("FAIL reset_tstrb got=%0h want=f", tstrb); end
      rst_n = 1'b1;
   endtask

   task automatic test_full_frame();
      tready = 1'b1;
      pulse_go(8, 8);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL ff_check_busy got=%0b want=1", busy); end
      total++; if (tvalid !== 1'b0) begin bad++; $display("FAIL ff_check_tvalid got=%0b want=0", tvalid); end
      @(negedge clk);
      total++; if (tvalid !== 1'b0) begin bad++; $display("FAIL ff_prime_tvalid got=%0b want=0", tvalid); end
      @(negedge clk);
      for (int b = 0; b < 64; b++) begin
         total++; if (tvalid !== 1'b1) begin bad++; $display("FAIL ff_tvalid beat=%0d got=%0b want=1", b, tvalid); end
         total++; if (tdata !== TW'(b)) begin bad++; $display("FAIL ff_tdata beat=%0d got=%0d want=%0d", b, tdata, b); end
         total++; if (tlast !== (b % 8 == 7)) begin bad++; $display("FAIL ff_tlast beat=%0d got=%0b want=%0b", b, tlast, (b % 8 == 7)); end
         total++; if (tuser !== (b == 0)) begin bad++; $display("FAIL ff_tuser beat=%0d got=%0b want=%0b", b, tuser, (b == 0)); end
         @(negedge clk);
      end
      total++; if (tvalid !== 1'b0) begin bad++; $display("FAIL ff_finish_tvalid got=%0b want=0", tvalid); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL ff_finish_done got=%0b want=0", done); end
      @(negedge clk);
      total++; if (done !== 1'b1) begin bad++; $display("FAIL ff_done got=%0b want=1", done); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL ff_idle_busy got=%0b want=0", busy); end
   endtask

   task automatic test_stall();
      bit [3:0] pat = 4'b1001;
      int w = 0;
      int beats = 0;
      int c = 0;
      tready = 1'b0;
      pulse_go(5, 5);
      while (!tvalid && w < 10) begin @(negedge clk); w++; end
      total++; if (w != 2) begin bad++; $display("FAIL st_latency got=%0d want=2", w); end
      while (beats < 25 && c < 200) begin
         total++; if (tvalid !== 1'b1) begin bad++; $display("FAIL st_tvalid beat=%0d got=%0b want=1", beats, tvalid); end
         total++; if (tdata !== TW'(beats)) begin bad++; $display("FAIL st_tdata beat=%0d got=%0d want=%0d", beats, tdata, beats); end
         total++; if (tlast !== (beats % 5 == 4)) begin bad++; $display("FAIL st_tlast beat=%0d got=%0b want=%0b", beats, tlast, (beats % 5 == 4)); end
         total++; if (tuser !== (beats == 0)) begin bad++; $display("FAIL st_tuser beat=%0d got=%0b want=%0b", beats, tuser, (beats == 0)); end
         tready = pat[c % 4];
         @(negedge clk);
         if (tready) beats++;
         c++;
      end
      total++; if (c >= 200) begin bad++; $display("FAIL st_timeout got=%0d want<200 cycles", c); end
      total++; if (tvalid !== 1'b0) begin bad++; $display("FAIL st_end_tvalid got=%0b want=0", tvalid); end
      @(negedge clk);
      total++; if (done !== 1'b1) begin bad++; $display("FAIL st_done got=%0b want=1", done); end
   endtask

   task automatic test_error();
      int ex[3] = '{0, 80, 64};
      int ey[3] = '{5, 80, 65};
      int seen;
      for (int k = 0; k < 3; k++) begin
         pulse_go(ex[k], ey[k]);
         total++; if (busy !== 1'b1) begin bad++; $display("FAIL err_check_busy case=%0d got=%0b want=1", k, busy); end
         @(negedge clk);
         total++; if (busy !== 1'b0) begin bad++; $display("FAIL err_busy case=%0d got=%0b want=0", k, busy); end
         total++; if (error !== 1'b1) begin bad++; $display("FAIL err_error case=%0d got=%0b want=1", k, error); end
         total++; if (done !== 1'b0) begin bad++; $display("FAIL err_done case=%0d got=%0b want=0", k, done); end
         seen = 0;
         for (int i = 0; i < 4; i++) begin
            if (tvalid) seen++;
            @(negedge clk);
         end
         total++; if (seen != 0) begin bad++; $display("FAIL err_beats case=%0d got=%0d want=0", k, seen); end
      end
      // exactly full capacity is legal
      tready = 1'b0;
      pulse_go(64, 64);
      total++; if (error !== 1'b0) begin bad++; $display("FAIL err_clear got=%0b want=0", error); end
      @(negedge clk);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL err_cap_busy got=%0b want=1", busy); end
      @(negedge clk);
      total++; if (tvalid !== 1'b1) begin bad++; $display("FAIL err_cap_tvalid got=%0b want=1", tvalid); end
      total++; if (tuser !== 1'b1) begin bad++; $display("FAIL err_cap_tuser got=%0b want=1", tuser); end
      #1 rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset_mid();
      int beats;
      bit reached;
      tready = 1'b1;
      pulse_go(8, 8);
      repeat (2) @(negedge clk);
      repeat (20) @(negedge clk);
      total++; if (tdata !== TW'(20)) begin bad++; $display("FAIL rm_beat20 got=%0d want=20", tdata); end
      #1 rst_n = 1'b0;
      #1;
      total++; if (tvalid !== 1'b0) begin bad++; $display("FAIL rm_tvalid got=%0b want=0", tvalid); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rm_busy got=%0b want=0", busy); end
      total++; if (tdata !== '0) begin bad++; $display("FAIL rm_tdata got=%0h want=0", tdata); end
      @(negedge clk);
      rst_n = 1'b1;
      pulse_go(8, 8);
      repeat (2) @(negedge clk);
      total++; if (tdata !== '0) begin bad++; $display("FAIL rm_restart_tdata got=%0d want=0", tdata); end
      total++; if (tuser !== 1'b1) begin bad++; $display("FAIL rm_restart_tuser got=%0b want=1", tuser); end
      drain(200, beats, reached);
      total++; if (!reached || beats != 64) begin bad++; $display("FAIL rm_drain got=%0d beats done=%0b want=64 beats done=1", beats, reached); end
   endtask

   task automatic test_write_busy();
      int beats;
      bit reached;
      tready = 1'b0;
      pulse_go(8, 8);
      wr_en = 1'b1; wr_addr = '0; wr_data = 32'hDEADBEEF;
      @(negedge clk);
      @(negedge clk);
      wr_addr = AW'(1);
      @(negedge clk);
      wr_en = 1'b0;
      total++; if (tdata !== 32'd0) begin bad++; $display("FAIL wb_beat0 got=%0h want=0", tdata); end
      drain(200, beats, reached);
      total++; if (!reached || beats != 64) begin bad++; $display("FAIL wb_drain got=%0d beats done=%0b want=64 beats done=1", beats, reached); end
      tready = 1'b0;
      pulse_go(2, 1);
      @(negedge clk);
      @(negedge clk);
      total++; if (tdata !== 32'd0) begin bad++; $display("FAIL wb_next0 got=%0h want=0", tdata); end
      total++; if (tlast !== 1'b0) begin bad++; $display("FAIL wb_next0_tlast got=%0b want=0", tlast); end
      tready = 1'b1;
      @(negedge clk);
      total++; if (tdata !== 32'd1) begin bad++; $display("FAIL wb_next1 got=%0h want=1", tdata); end
      total++; if (tlast !== 1'b1) begin bad++; $display("FAIL wb_next1_tlast got=%0b want=1", tlast); end
      repeat (3) @(negedge clk);
      do_write(0, 32'hA5A5A5A5);
      pulse_go(1, 1);
      repeat (2) @(negedge clk);
      total++; if (tdata !== 32'hA5A5A5A5) begin bad++; $display("FAIL one_tdata got=%0h want=a5a5a5a5", tdata); end
      total++; if (tlast !== 1'b1) begin bad++; $display("FAIL one_tlast got=%0b want=1", tlast); end
      total++; if (tuser !== 1'b1) begin bad++; $display("FAIL one_tuser got=%0b want=1", tuser); end
      @(negedge clk);
      total++; if (tvalid !== 1'b0) begin bad++; $display("FAIL one_end_tvalid got=%0b want=0", tvalid); end
      @(negedge clk);
      total++; if (done !== 1'b1) begin bad++; $display("FAIL one_done got=%0b want=1", done); end
      do_write(0, 32'd0);
   endtask

`ifdef STAMP_SRC_REPEAT_EN
   task automatic test_back_to_back();
      tready = 1'b1;
      @(negedge clk);
      x_in = DW'(4); y_in = DW'(2); go = 1'b1;
      repeat (3) @(negedge clk);
      for (int b = 0; b < 16; b++) begin
         total++; if (tvalid !== 1'b1) begin bad++; $display("FAIL rp_tvalid beat=%0d got=%0b want=1", b, tvalid); end
         total++; if (tdata !== TW'(b % 8)) begin bad++; $display("FAIL rp_tdata beat=%0d got=%0d want=%0d", b, tdata, b % 8); end
         total++; if (tuser !== (b % 8 == 0)) begin bad++; $display("FAIL rp_tuser beat=%0d got=%0b want=%0b", b, tuser, (b % 8 == 0)); end
         total++; if (tlast !== (b % 4 == 3)) begin bad++; $display("FAIL rp_tlast beat=%0d got=%0b want=%0b", b, tlast, (b % 4 == 3)); end
         total++; if (done !== (b == 8)) begin bad++; $display("FAIL rp_done beat=%0d got=%0b want=%0b", b, done, (b == 8)); end
         if (b == 8) go = 1'b0;
         @(negedge clk);
      end
      total++; if (tvalid !== 1'b0) begin bad++; $display("FAIL rp_end_tvalid got=%0b want=0", tvalid); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL rp_finish_done got=%0b want=0", done); end
      @(negedge clk);
      total++; if (done !== 1'b1) begin bad++; $display("FAIL rp_done_final got=%0b want=1", done); end
      @(negedge clk);
      total++; if (done !== 1'b1) begin bad++; $display("FAIL rp_done_sticky got=%0b want=1", done); end
   endtask
`else
   task automatic test_go_level();
      int beats = 0;
      tready = 1'b1;
      @(negedge clk);
      x_in = DW'(2); y_in = DW'(2); go = 1'b1;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (tvalid) beats++;
      end
      total++; if (beats != 4) begin bad++; $display("FAIL gl_beats got=%0d want=4", beats); end
      total++; if (done !== 1'b1) begin bad++; $display("FAIL gl_done got=%0b want=1", done); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL gl_busy got=%0b want=0", busy); end
      go = 1'b0;
      @(negedge clk);
   endtask
`endif

   initial begin
      test_reset();
      load_ramp(64);
      test_full_frame();
      test_stall();
      test_error();
      test_reset_mid();
      test_write_busy();
`ifdef STAMP_SRC_REPEAT_EN
      test_back_to_back();
`else
      test_go_level();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
